// File: rtl/seq_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter: one shift/add-3 step per clock.
// Takes W+1 cycles per conversion; bcd holds the last completed result.
`timescale 1ns/1ps

module bcd_adj3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module seq_bin2bcd #(
  parameter int W = 10,
  parameter int D = (W / 3) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   bin_in,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  state_t         state_q, state_d;
  logic           start_q, start_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [4*D-1:0] scr_q, scr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [4*D-1:0] bcd_q, bcd_d;

  logic [4*D-1:0]   adj;
  logic [4*D+W-1:0] step;

  // Per-digit +3 correction, applied to every nibble before the shift.
  for (genvar g = 0; g < D; g++) begin : g_dig
    bcd_adj3 u_adj (
      .nib_i (scr_q[4*g +: 4]),
      .nib_o (adj[4*g +: 4])
    );
  end

  assign step = {adj, shift_q} << 1;

  always_comb begin
    state_d = state_q;
    start_d = start;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          state_d = SHIFT;
          shift_d = bin_in;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        scr_d   = step[4*D+W-1:W];
        shift_d = step[W-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          bcd_d   = step[4*D+W-1:W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboarded bench for seq_bin2bcd: expected BCD and completion cycle queued at launch,
// checked when done pulses.
`timescale 1ns/1ps

module tb_seq_bin2bcd;
  localparam int W = 10;
  localparam int D = (W / 3) + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   bin_in = '0;
  logic           busy, done;
  logic [4*D-1:0] bcd;

  seq_bin2bcd #(.W(W), .D(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [4*D-1:0] val;
    int             due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   dones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Done monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && done) begin
      dones++;
      chk("sb_pending", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("bcd", bcd, e.val);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic launch(input int v, input logic [4*D-1:0] ev, input bit push);
    @(negedge clk);
    bin_in = W'(v);
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (push) sbq.push_back('{ev, cyc + W});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sbq.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 40), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int v;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    reset = 1'b1;

    // Basic conversion with busy window
    launch(780, 16'h0780, 1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      chk("t1_busy", busy, 1);
      chk("t1_no_early_done", done, 0);
    end
    @(negedge clk);
    chk("t1_busy_end", busy, 0);
    chk("t1_done", done, 1);

    // Back-to-back: restart while done is high
    bin_in = W'(169);
    start  = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{16'h0169, cyc + W});
    @(negedge clk);
    chk("t2_done_single", done, 0);
    start = 1'b0;
    wait_idle("t2_timeout");
    chk("t2_bcd", bcd, 16'h0169);

    // Boundaries
    launch(0, 16'h0000, 1);    @(negedge clk); start = 1'b0; wait_idle("t3_zero");
    launch(1023, 16'h1023, 1); @(negedge clk); start = 1'b0; wait_idle("t3_max");
    launch(999, 16'h0999, 1);  @(negedge clk); start = 1'b0; wait_idle("t3_999");

    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(0, 1023));
      launch(v, to_bcd(v), 1);
      @(negedge clk);
      start = 1'b0;
      wait_idle("rand_timeout");
    end

    // Held start triggers once
    d0 = dones;
    launch(512, 16'h0512, 1);
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_idle("t4_timeout");
    chk("t4_one_done", dones - d0, 1);
    chk("t4_bcd", bcd, 16'h0512);

    // Start pulse while busy is ignored
    d0 = dones;
    launch(300, 16'h0300, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin_in = W'(7);
    start  = 1'b1;
    chk("t5_bcd_stable", bcd, 16'h0512);
    @(negedge clk);
    start = 1'b0;
    wait_idle("t5_timeout");
    repeat (3) @(negedge clk);
    chk("t5_one_done", dones - d0, 1);
    chk("t5_bcd", bcd, 16'h0300);

    // Async reset mid-conversion
    launch(999, 16'h0999, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #5 reset = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_bcd", bcd, 0);
    d0 = dones;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_no_done", dones - d0, 0);
    chk("t6_bcd_zero", bcd, 0);
    launch(42, 16'h0042, 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle("t6_timeout");
    chk("t6_bcd", bcd, 16'h0042);

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
